// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
// The master holds the request fields stable from the first REQ cycle through the ACK cycle.
interface mem_access_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [3:0]        MEM_STRB;
    logic [31:0]       MEM_WDATA;
    logic              MEM_ACK;
    logic [31:0]       MEM_RDATA;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA,
        input  MEM_ACK, MEM_RDATA
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA,
        output MEM_ACK, MEM_RDATA
    );
endinterface

// File: rtl/mem_access.sv
// EX->MEM pipeline stage for the RV32I core: captures ALU results, performs the data-memory
// load/store over a req/ack bus, aligns load data and presents the writeback result.
// Optional build macro MEM_ACCESS_MISALIGN_CHK_EN adds a misaligned-access fault check.
module mem_access #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 0   // 0 = wait for MEM_ACK forever
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STALL,
    input  logic              FLUSH,
    output logic              BUSY,
    output logic              DO_JMP,
    output logic [31:0]       NEW_PC,
    input  logic [31:0]       A_PC,
    input  logic [31:0]       A_INST,
    input  logic              A_VALID,
    input  logic              A_DO_JMP,
    input  logic [31:0]       A_NEW_PC,
    input  logic [4:0]        A_REG_D,
    input  logic [31:0]       A_REG_D_V,
    input  logic              A_LOAD_REN,
    input  logic              A_STORE_WREN,
    input  logic [2:0]        A_FUNCT3,
    input  logic [ADDR_W-1:0] A_MEM_ADDR,
    input  logic [3:0]        A_STORE_STRB,
    input  logic [31:0]       A_STORE_DATA,
    mem_access_if.master      mem,
    output logic [31:0]       M_PC,
    output logic [31:0]       M_INST,
    output logic              M_VALID,
    output logic [4:0]        M_REG_D,
    output logic [31:0]       M_REG_D_V,
    output logic              M_FAULT
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    logic [0:0]        state_q;
    logic              valid_q;
    logic [31:0]       pc_q;
    logic [31:0]       inst_q;
    logic              do_jmp_q;
    logic [31:0]       new_pc_q;
    logic [4:0]        reg_d_q;
    logic [31:0]       reg_d_v_q;
    logic              load_q;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        strb_q;
    logic [31:0]       wdata_q;
    logic              fault_q;
    logic [31:0]       cnt_q;

    logic              advance;
    logic              misaligned;
    logic              start_mem;
    logic              timeout_hit;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [31:0]       load_aligned;

    assign advance = !STALL && (state_q == StIdle);

`ifdef MEM_ACCESS_MISALIGN_CHK_EN
    assign misaligned = A_VALID && (A_LOAD_REN || A_STORE_WREN) &&
                        (((A_FUNCT3[1:0] == 2'b01) && A_MEM_ADDR[0]) ||
                         ((A_FUNCT3[1:0] == 2'b10) && (A_MEM_ADDR[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign start_mem   = A_VALID && (A_LOAD_REN || A_STORE_WREN) && !misaligned;
    // Last permitted wait cycle; an ACK in the same cycle still wins.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);

    // Select and extend the load lane addressed by the held byte address.
    always_comb begin
        load_byte = mem.MEM_RDATA[{addr_q[1:0], 3'b000} +: 8];
        load_half = addr_q[1] ? mem.MEM_RDATA[31:16] : mem.MEM_RDATA[15:0];
        case (funct3_q)
            3'b000:  load_aligned = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_aligned = {{16{load_half[15]}}, load_half};
            3'b100:  load_aligned = {24'h0, load_byte};
            3'b101:  load_aligned = {16'h0, load_half};
            default: load_aligned = mem.MEM_RDATA;
        endcase
    end

    // Pipeline register capture, FSM and timeout counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            inst_q    <= '0;
            do_jmp_q  <= 1'b0;
            new_pc_q  <= '0;
            reg_d_q   <= '0;
            reg_d_v_q <= '0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            funct3_q  <= '0;
            addr_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else if (advance) begin
            cnt_q <= '0;
            if (FLUSH) begin
                state_q   <= StIdle;
                valid_q   <= 1'b0;
                pc_q      <= '0;
                inst_q    <= '0;
                do_jmp_q  <= 1'b0;
                new_pc_q  <= '0;
                reg_d_q   <= '0;
                reg_d_v_q <= '0;
                load_q    <= 1'b0;
                store_q   <= 1'b0;
                funct3_q  <= '0;
                addr_q    <= '0;
                strb_q    <= '0;
                wdata_q   <= '0;
                fault_q   <= 1'b0;
            end else begin
                state_q   <= start_mem ? StWait : StIdle;
                valid_q   <= A_VALID;
                pc_q      <= A_PC;
                inst_q    <= A_INST;
                do_jmp_q  <= A_DO_JMP;
                new_pc_q  <= A_NEW_PC;
                reg_d_q   <= misaligned ? 5'd0 : A_REG_D;
                reg_d_v_q <= A_REG_D_V;
                load_q    <= A_LOAD_REN;
                store_q   <= A_STORE_WREN;
                funct3_q  <= A_FUNCT3;
                addr_q    <= A_MEM_ADDR;
                strb_q    <= A_STORE_STRB;
                wdata_q   <= A_STORE_DATA;
                fault_q   <= misaligned;
            end
        end else if (state_q == StWait) begin
            // A flush kills the writeback but the bus transaction runs to completion.
            if (FLUSH) begin
                valid_q  <= 1'b0;
                do_jmp_q <= 1'b0;
                reg_d_q  <= '0;
                fault_q  <= 1'b0;
            end
            if (mem.MEM_ACK) begin
                state_q <= StIdle;
                if (load_q) begin
                    reg_d_v_q <= load_aligned;
                end
            end else if (timeout_hit) begin
                state_q <= StIdle;
                cnt_q   <= TIMEOUT;
                reg_d_q <= '0;
                if (!FLUSH) begin
                    fault_q <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // Bus drive: request fields come from held registers so they are stable all request long.
    always_comb begin
        mem.MEM_REQ   = 1'b0;
        mem.MEM_WE    = 1'b0;
        mem.MEM_ADDR  = '0;
        mem.MEM_STRB  = '0;
        mem.MEM_WDATA = '0;
        if (state_q == StWait) begin
            mem.MEM_REQ   = 1'b1;
            mem.MEM_WE    = store_q;
            mem.MEM_ADDR  = {addr_q[ADDR_W-1:2], 2'b00};
            mem.MEM_STRB  = store_q ? strb_q : 4'b1111;
            mem.MEM_WDATA = store_q ? wdata_q : 32'h0;
        end
    end

    // Stage outputs; writeback valid is withheld while the access is outstanding.
    always_comb begin
        BUSY      = (state_q == StWait);
        DO_JMP    = do_jmp_q;
        NEW_PC    = new_pc_q;
        M_PC      = pc_q;
        M_INST    = inst_q;
        M_VALID   = valid_q && (state_q == StIdle);
        M_REG_D   = reg_d_q;
        M_REG_D_V = reg_d_v_q;
        M_FAULT   = fault_q;
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access (TIMEOUT=4): directed scenarios plus randomized
// loads/stores checked against an arithmetic model of RV32I load alignment.
module tb_mem_access;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL, FLUSH;
  logic        BUSY, DO_JMP;
  logic [31:0] NEW_PC;
  logic [31:0] A_PC, A_INST, A_NEW_PC, A_REG_D_V, A_MEM_ADDR, A_STORE_DATA;
  logic        A_VALID, A_DO_JMP, A_LOAD_REN, A_STORE_WREN;
  logic [4:0]  A_REG_D;
  logic [2:0]  A_FUNCT3;
  logic [3:0]  A_STORE_STRB;
  logic [31:0] M_PC, M_INST, M_REG_D_V;
  logic        M_VALID, M_FAULT;
  logic [4:0]  M_REG_D;

  int checks = 0;
  int errors = 0;

  mem_access_if #(.ADDR_W(32)) bus ();

  mem_access #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .BUSY(BUSY),
    .DO_JMP(DO_JMP), .NEW_PC(NEW_PC), .A_PC(A_PC), .A_INST(A_INST),
    .A_VALID(A_VALID), .A_DO_JMP(A_DO_JMP), .A_NEW_PC(A_NEW_PC),
    .A_REG_D(A_REG_D), .A_REG_D_V(A_REG_D_V), .A_LOAD_REN(A_LOAD_REN),
    .A_STORE_WREN(A_STORE_WREN), .A_FUNCT3(A_FUNCT3), .A_MEM_ADDR(A_MEM_ADDR),
    .A_STORE_STRB(A_STORE_STRB), .A_STORE_DATA(A_STORE_DATA), .mem(bus),
    .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID), .M_REG_D(M_REG_D),
    .M_REG_D_V(M_REG_D_V), .M_FAULT(M_FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: value a RV32I load writes back, from funct3, byte address and bus word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * (addr % 4))) % 256;
    h = (word >> (16 * ((addr / 2) % 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  task automatic drive_a(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdv);
    A_VALID      = 1'b1;
    A_LOAD_REN   = ld;
    A_STORE_WREN = st;
    A_FUNCT3     = f3;
    A_MEM_ADDR   = addr;
    A_REG_D      = rd;
    A_REG_D_V    = rdv;
    A_PC         = $urandom;
    A_INST       = $urandom;
    A_DO_JMP     = 1'($urandom);
    A_NEW_PC     = $urandom;
  endtask

  task automatic idle_a();
    A_VALID      = 1'b0;
    A_LOAD_REN   = 1'b0;
    A_STORE_WREN = 1'b0;
  endtask

  // One complete access with ACK after dly extra wait cycles; checks bus and writeback.
  task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        input logic [31:0] rdv, input int dly);
    logic [31:0] exp_pc, exp_npc;
    logic        exp_jmp;
    @(negedge CLK);
    drive_a(ld, !ld, f3, addr, rd, rdv);
    A_STORE_STRB = strb;
    A_STORE_DATA = wdata;
    exp_pc  = A_PC;
    exp_npc = A_NEW_PC;
    exp_jmp = A_DO_JMP;
    @(negedge CLK);
    idle_a();
    for (int c = 0; c <= dly; c++) begin
      check("busy", BUSY, 1'b1);
      check("req", bus.MEM_REQ, 1'b1);
      check("we", bus.MEM_WE, !ld);
      check("addr", bus.MEM_ADDR, addr - (addr % 4));
      check("strb", bus.MEM_STRB, ld ? 4'hF : strb);
      if (!ld) check("wdata", bus.MEM_WDATA, wdata);
      check("mvalid_wait", M_VALID, 1'b0);
      if (c == dly) begin
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = rdata;
      end
      @(negedge CLK);
      bus.MEM_ACK   = 1'b0;
      bus.MEM_RDATA = $urandom;
    end
    check("busy_done", BUSY, 1'b0);
    check("req_done", bus.MEM_REQ, 1'b0);
    check("mvalid", M_VALID, 1'b1);
    check("reg_d", M_REG_D, rd);
    check("reg_d_v", M_REG_D_V, ld ? ref_load(f3, addr, rdata) : rdv);
    check("fault", M_FAULT, 1'b0);
    check("pc", M_PC, exp_pc);
    check("do_jmp", DO_JMP, exp_jmp);
    check("new_pc", NEW_PC, exp_npc);
  endtask

  initial begin
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
    A_PC = '0; A_INST = '0; A_NEW_PC = '0; A_REG_D_V = '0; A_MEM_ADDR = '0;
    A_STORE_DATA = '0; A_DO_JMP = 1'b0; A_REG_D = '0; A_FUNCT3 = '0; A_STORE_STRB = '0;
    idle_a();
    bus.MEM_ACK = 1'b0; bus.MEM_RDATA = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Reset state
    check("rst_busy", BUSY, 1'b0);
    check("rst_req", bus.MEM_REQ, 1'b0);
    check("rst_mvalid", M_VALID, 1'b0);
    check("rst_reg_d_v", M_REG_D_V, 32'h0);
    check("rst_fault", M_FAULT, 1'b0);
    check("rst_jmp", DO_JMP, 1'b0);

    // LB at 0x103, ACK one cycle after REQ
    run_op(1'b1, 3'd0, 32'h103, 4'h0, 32'h0, 32'h80FF_1234, 5'd3, 32'h5555, 1);
    check("lb_value", M_REG_D_V, 32'hFFFF_FF80);
    // SW at 0x200, ACK same cycle as REQ
    run_op(1'b0, 3'd2, 32'h200, 4'hF, 32'hDEAD_BEEF, 32'h0, 5'd4, 32'h0BAD_F00D, 0);

    // FLUSH during WAIT of an LW
    @(negedge CLK);
    drive_a(1'b1, 1'b0, 3'd2, 32'h300, 5'd9, 32'h1);
    @(negedge CLK);
    idle_a();
    FLUSH = 1'b1;
    check("flush_req0", bus.MEM_REQ, 1'b1);
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush_req1", bus.MEM_REQ, 1'b1);
    check("flush_busy1", BUSY, 1'b1);
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h1234_5678;
    @(negedge CLK);
    bus.MEM_ACK = 1'b0;
    check("flush_busy", BUSY, 1'b0);
    check("flush_mvalid", M_VALID, 1'b0);
    check("flush_reg_d", M_REG_D, 5'd0);
    check("flush_jmp", DO_JMP, 1'b0);

    // Timeout: no ACK, REQ for exactly four cycles
    @(negedge CLK);
    drive_a(1'b1, 1'b0, 3'd2, 32'h400, 5'd11, 32'hCAFE);
    @(negedge CLK);
    idle_a();
    for (int c = 0; c < 4; c++) begin
      check("to_req", bus.MEM_REQ, 1'b1);
      @(negedge CLK);
    end
    STALL = 1'b1;
    check("to_req_drop", bus.MEM_REQ, 1'b0);
    check("to_busy", BUSY, 1'b0);
    check("to_fault", M_FAULT, 1'b1);
    check("to_reg_d", M_REG_D, 5'd0);
    check("to_mvalid", M_VALID, 1'b1);
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hFFFF_FFFF;
    @(negedge CLK);
    bus.MEM_ACK = 1'b0;
    check("late_ack_fault", M_FAULT, 1'b1);
    check("late_ack_reg_d_v", M_REG_D_V, 32'hCAFE);
    check("late_ack_busy", BUSY, 1'b0);
    check("late_ack_req", bus.MEM_REQ, 1'b0);
    STALL = 1'b0;

    // STALL during ACK of LHU at 0x102; next instruction waits for STALL to drop
    @(negedge CLK);
    drive_a(1'b1, 1'b0, 3'd5, 32'h102, 5'd12, 32'h0);
    @(negedge CLK);
    idle_a();
    STALL = 1'b1;
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hABCD_0000;
    @(negedge CLK);
    bus.MEM_ACK = 1'b0;
    drive_a(1'b0, 1'b0, 3'd0, 32'h0, 5'd7, 32'h1234);
    check("lhu_value", M_REG_D_V, 32'h0000_ABCD);
    check("lhu_mvalid", M_VALID, 1'b1);
    @(negedge CLK);
    check("stall_hold_v", M_REG_D_V, 32'h0000_ABCD);
    check("stall_hold_rd", M_REG_D, 5'd12);
    STALL = 1'b0;
    @(negedge CLK);
    idle_a();
    check("post_stall_rd", M_REG_D, 5'd7);
    check("post_stall_v", M_REG_D_V, 32'h1234);
    check("post_stall_fault", M_FAULT, 1'b0);

`ifdef MEM_ACCESS_MISALIGN_CHK_EN
    // Misaligned LW: no bus request, faulting writeback next cycle
    @(negedge CLK);
    drive_a(1'b1, 1'b0, 3'd2, 32'h101, 5'd13, 32'h77);
    @(negedge CLK);
    idle_a();
    check("mis_req", bus.MEM_REQ, 1'b0);
    check("mis_busy", BUSY, 1'b0);
    check("mis_fault", M_FAULT, 1'b1);
    check("mis_mvalid", M_VALID, 1'b1);
    check("mis_reg_d", M_REG_D, 5'd0);
`endif

    // Randomized loads and stores
    for (int i = 0; i < 40; i++) begin
      ld   = 1'($urandom);
      f3   = ld ? 3'($urandom) : 3'($urandom_range(2, 0));
      addr = $urandom;
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
      if (f3[1:0] == 2'b01) addr[0] = 1'b0;
      if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
`endif
      run_op(ld, f3, addr, 4'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
             int'($urandom_range(3, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
